irq_controller: RTL and testbench

- Memory-mapped interrupt controller between the peripheral interrupt sources (timer, UART rx, UART tx, switch change) and the Control unit's IRQ input.
- Latches source edges into pending bits, masks them with an enable register, selects the highest-priority request and drives irqout.
- Tracks whether the CPU has taken the interrupt (PC[31] supervisor bit rising) and holds further requests until the handler writes end-of-interrupt (EOI).
- Sits on the same rd/wr/addr/wdata/rdata bus as DataMem and Peripheral.

---
 rtl/irq_controller.sv | 122 ++++++++++++
 tb/tb_irq_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: latches source rising edges into pending
// bits, masks with IE, raises one prioritized request and holds it until EOI.
module irq_controller #(
  parameter int unsigned NSRC = 4,
  parameter logic [31:0] BASE = 32'h40000030
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [NSRC-1:0] src_i,
  input  logic            supervisor_i,
  input  logic            rd_i,
  input  logic            wr_i,
  input  logic [31:0]     addr_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o,
  output logic            irqout_o,
  output logic [1:0]      irq_id_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_e;

  state_e          state_q;
  logic [NSRC-1:0] ie_q, ie_d, pend_q, pend_d, src_q;
  logic [NSRC-1:0] rise, req, w1c_mask, take_mask;
  logic            irqout_q;
  logic [1:0]      irq_id_q, winner;
  logic [3:0]      pend4, ie4, take4;
  logic            hit, wr_ie, wr_pend, wr_eoi, take, req_live;
  logic            unused_bits;

  assign hit     = (addr_i[31:4] == BASE[31:4]);
  assign wr_ie   = wr_i && hit && (addr_i[3:2] == 2'd0);
  assign wr_pend = wr_i && hit && (addr_i[3:2] == 2'd1);
  assign wr_eoi  = wr_i && hit && (addr_i[3:2] == 2'd3);

  assign rise = src_i & ~src_q;
  assign req  = pend_q & ie_q;

  // Padded 4-bit views so irq_id can index safely for any NSRC.
  always_comb begin
    pend4 = '0;
    ie4   = '0;
    pend4[NSRC-1:0] = pend_q;
    ie4[NSRC-1:0]   = ie_q;
  end

  assign req_live  = pend4[irq_id_q] & ie4[irq_id_q];
  assign take      = (state_q == REQ) && supervisor_i;
  assign take4     = 4'b0001 << irq_id_q;
  assign take_mask = take ? take4[NSRC-1:0] : '0;
  assign w1c_mask  = wr_pend ? wdata_i[NSRC-1:0] : '0;
  assign pend_d    = (pend_q & ~w1c_mask & ~take_mask) | rise;
  assign ie_d      = wr_ie ? wdata_i[NSRC-1:0] : ie_q;

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) winner = 2'(i);
    end
  end

  always_comb begin
    rdata_o = '0;
    if (rd_i && hit) begin
      case (addr_i[3:2])
        2'd0: rdata_o[NSRC-1:0] = ie_q;
        2'd1: rdata_o[NSRC-1:0] = pend_q;
        2'd2: begin
          rdata_o[1:0] = irq_id_q;
          rdata_o[8]   = (state_q == REQ);
          rdata_o[9]   = (state_q == SERVICE);
        end
        default: rdata_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      ie_q     <= '0;
      pend_q   <= '0;
      src_q    <= '0;
      irqout_q <= 1'b0;
      irq_id_q <= '0;
    end else begin
      src_q  <= src_i;
      pend_q <= pend_d;
      ie_q   <= ie_d;
      case (state_q)
        IDLE: begin
          if ((|req) && !supervisor_i) begin
            irq_id_q <= winner;
            irqout_q <= 1'b1;
            state_q  <= REQ;
          end
        end
        REQ: begin
          // irq_id stays frozen here; a later higher-priority edge waits.
          if (supervisor_i) begin
            irqout_q <= 1'b0;
            state_q  <= SERVICE;
          end else if (!req_live) begin
            irqout_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        SERVICE: begin
          if (wr_eoi) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign irqout_o = irqout_q;
  assign irq_id_o = irq_id_q;

  assign unused_bits = ^{addr_i[1:0], wdata_i};

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: a per-cycle behavioural model plus
// hand-computed literal expectations from the documented scenarios.
module tb_irq_controller;

  localparam logic [31:0] BASE = 32'h40000030;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  src = '0;
  logic        sup = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        irqout;
  logic [1:0]  irq_id;

  int pass_cnt = 0;
  int total_cnt = 0;

  irq_controller #(.NSRC(4), .BASE(BASE)) dut (
    .clk_i(clk), .reset_i(reset), .src_i(src), .supervisor_i(sup),
    .rd_i(rd), .wr_i(wr), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata), .irqout_o(irqout), .irq_id_o(irq_id)
  );

  always #5 clk = ~clk;

  // Model state: mode 0 = idle, 1 = requesting, 2 = in service.
  bit m_ie[4], m_pend[4], m_prev[4];
  int m_mode = 0, m_id = 0;
  bit m_irq = 0, m_valid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic logic [31:0] model_rdata();
    logic [31:0] r;
    r = '0;
    if (rd && addr[31:4] == BASE[31:4]) begin
      case (addr[3:2])
        2'd0: for (int i = 0; i < 4; i++) r[i] = m_ie[i];
        2'd1: for (int i = 0; i < 4; i++) r[i] = m_pend[i];
        2'd2: r = m_id + (m_mode == 1 ? 32'h100 : 0) + (m_mode == 2 ? 32'h200 : 0);
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // Predict the next state from current inputs, advance one clock, compare.
  task automatic step();
    bit n_ie[4], n_pend[4], n_prev[4];
    int n_mode, n_id, win, take, sel;
    bit n_irq, hitb, rise, clr;
    hitb = (addr[31:4] == BASE[31:4]);
    sel  = int'(addr[3:2]);
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        n_ie[i] = 0; n_pend[i] = 0; n_prev[i] = 0;
      end
      n_mode = 0; n_id = 0; n_irq = 0;
    end else begin
      win = -1;
      for (int i = 3; i >= 0; i--) if (m_pend[i] && m_ie[i]) win = i;
      n_mode = m_mode; n_id = m_id; n_irq = m_irq; take = -1;
      if (m_mode == 0) begin
        if (win >= 0 && !sup) begin n_id = win; n_irq = 1; n_mode = 1; end
      end else if (m_mode == 1) begin
        if (sup) begin take = m_id; n_irq = 0; n_mode = 2; end
        else if (!(m_pend[m_id] && m_ie[m_id])) begin n_irq = 0; n_mode = 0; end
      end else begin
        if (wr && hitb && sel == 3) n_mode = 0;
      end
      for (int i = 0; i < 4; i++) begin
        rise = src[i] && !m_prev[i];
        clr  = (wr && hitb && sel == 1 && wdata[i]) || (take == i);
        n_pend[i] = (m_pend[i] && !clr) || rise;
        n_ie[i]   = (wr && hitb && sel == 0) ? wdata[i] : m_ie[i];
        n_prev[i] = src[i];
      end
    end
    @(posedge clk);
    #1;
    m_ie = n_ie; m_pend = n_pend; m_prev = n_prev;
    m_mode = n_mode; m_id = n_id; m_irq = n_irq;
    if (reset) m_valid = 1;
    if (m_valid) begin
      chk("irqout", {31'b0, irqout}, {31'b0, m_irq});
      chk("irq_id", {30'b0, irq_id}, m_id);
      chk("rdata", rdata, model_rdata());
    end
  endtask

  task automatic wr_reg(input int sel, input logic [31:0] d);
    wr = 1; addr = BASE + 32'(sel * 4); wdata = d;
    step();
    wr = 0; addr = '0; wdata = '0;
  endtask

  task automatic rd_at(input logic [31:0] a, input logic [31:0] exp, input string name);
    rd = 1; addr = a;
    #1;
    chk(name, rdata, exp);
    rd = 0; addr = '0;
  endtask

  task automatic rd_reg(input int sel, input logic [31:0] exp, input string name);
    rd_at(BASE + 32'(sel * 4), exp, name);
  endtask

  initial begin
    // Reset state
    reset = 1; step(); step(); reset = 0;
    chk("rst_irqout", {31'b0, irqout}, 0);
    rd_reg(0, 0, "rst_ie");
    rd_reg(1, 0, "rst_pend");
    rd_reg(2, 0, "rst_vec");

    // Single source, 2-cycle latency, take by supervisor
    wr_reg(0, 32'h1);
    src = 4'b0001; step(); src = '0;
    rd_reg(1, 32'h1, "t1_pend_after1");
    chk("t1_irq_after1", {31'b0, irqout}, 0);
    step();
    chk("t1_irq_after2", {31'b0, irqout}, 1);
    chk("t1_id", {30'b0, irq_id}, 0);
    rd_reg(2, 32'h100, "t1_vec_req");
    sup = 1; step();
    chk("t1_irq_taken", {31'b0, irqout}, 0);
    rd_reg(1, 0, "t1_pend_taken");
    rd_reg(2, 32'h200, "t1_vec_service");
    wr_reg(3, 0);
    sup = 0; step();

    // Two simultaneous edges, priority, EOI then next request
    wr_reg(0, 32'hF);
    src = 4'b1010; step(); src = '0;
    step();
    chk("t2_id_first", {30'b0, irq_id}, 1);
    sup = 1; step();
    sup = 0; wr_reg(3, 0);
    chk("t2_irq_at_eoi", {31'b0, irqout}, 0);
    step();
    chk("t2_irq_next", {31'b0, irqout}, 1);
    chk("t2_id_next", {30'b0, irq_id}, 3);
    sup = 1; step();
    wr_reg(3, 0); sup = 0;

    // Masked pending, then enable
    wr_reg(0, 0);
    src = 4'b0100; step(); src = '0; step();
    rd_reg(1, 32'h4, "t3_pend");
    chk("t3_irq_masked", {31'b0, irqout}, 0);
    wr_reg(0, 32'h4);
    step();
    chk("t3_irq", {31'b0, irqout}, 1);
    chk("t3_id", {30'b0, irq_id}, 2);
    sup = 1; step();
    wr_reg(3, 0); sup = 0;

    // Withdraw by masking while requesting
    wr_reg(0, 32'h1);
    src = 4'b0001; step(); src = '0; step();
    chk("t4_irq_req", {31'b0, irqout}, 1);
    wr_reg(0, 0);
    step();
    chk("t4_irq_withdrawn", {31'b0, irqout}, 0);
    rd_reg(2, 0, "t4_vec_idle");
    rd_reg(1, 32'h1, "t4_pend_kept");
    wr_reg(1, 32'h1);

    // W1C racing a new edge
    src = 4'b0010; wr_reg(1, 32'h2); src = '0;
    rd_reg(1, 32'h2, "t5_pend_race");
    wr_reg(1, 32'h2);
    rd_reg(1, 0, "t5_pend_cleared");

    // Bus misses
    wr = 1; addr = BASE + 32'h10; wdata = 32'hF; step(); wr = 0; addr = '0; wdata = '0;
    rd_reg(0, 0, "miss_wr_ignored");
    wr_reg(0, 32'hF);
    rd_at(BASE + 32'h10, 0, "miss_rd_zero");

    // Reset in SERVICE with pending work
    wr_reg(0, 32'h1);
    src = 4'b0001; step(); src = '0; step();
    sup = 1; step();
    src = 4'b1010; step(); src = '0;
    rd_reg(1, 32'hA, "t6_pend_pre");
    rd_reg(2, 32'h200, "t6_vec_pre");
    reset = 1; step(); reset = 0;
    rd_reg(0, 0, "t6_ie_rst");
    rd_reg(1, 0, "t6_pend_rst");
    rd_reg(2, 0, "t6_vec_rst");
    chk("t6_irq_rst", {31'b0, irqout}, 0);
    rd_reg(3, 0, "t6_eoi_rd");
    sup = 0; step(); step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
